// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, standard divisor and divider sizing.
// The transmit side reuses these so both directions agree on encodings.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_state_e;

  localparam int UART_DIV_115200 = 434;

  // Bits needed for a down-counter that reloads with div-1.
  function automatic int div_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// N-stage single-bit synchroniser for an asynchronous input.
// Resets to 1 so an idle-high serial line never looks like a start bit.
module sync_ff #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic reset_in,
  input  logic d,
  output logic q
);

  logic [N-1:0] stg;

  always_ff @(posedge clk) begin
    if (!reset_in) stg <= '1;
    else           stg <= {stg[N-2:0], d};
  end

  assign q = stg[N-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-bit validation, mid-bit sampling, stop check,
// and a single-entry holding register with a valid/ack handshake.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_DIV     = UART_DIV_115200,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_in,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       overrun,
  output logic       frame_err,
  output logic       busy
);

  localparam int             DW      = div_width(CLK_DIV);
  localparam logic [DW-1:0]  HALF_LD = DW'(CLK_DIV/2 - 1);
  localparam logic [DW-1:0]  FULL_LD = DW'(CLK_DIV - 1);

  logic          rxs;
  uart_state_e   state;
  logic [DW-1:0] div_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          tick;
  logic          commit;

  sync_ff #(.N(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .reset_in (reset_in),
    .d        (rxd),
    .q        (rxs)
  );

  assign tick   = (div_cnt == '0);
  assign commit = (state == STOP) && tick && rxs;

  always_ff @(posedge clk) begin
    if (!reset_in) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (state != IDLE && state != BREAK)
        div_cnt <= tick ? FULL_LD : div_cnt - 1'b1;

      // A commit with a simultaneous ack replaces the byte; overrun is left alone.
      if (commit) begin
        if (!rx_valid) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else if (rx_ack) begin
          rx_data  <= shreg;
        end else begin
          overrun  <= 1'b1;
        end
      end else if (rx_ack && rx_valid) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end

      case (state)
        IDLE: if (!rxs) begin
          div_cnt <= HALF_LD;
          state   <= START;
          busy    <= 1'b1;
        end
        START: if (tick) begin
          if (rxs) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: if (tick) begin
          shreg[bit_idx] <= rxs;
          bit_idx        <= bit_idx + 1'b1;
          if (bit_idx == 3'd7) state <= STOP;
        end
        STOP: if (tick) begin
          if (rxs) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            frame_err <= 1'b1;
            state     <= BREAK;
          end
        end
        // Held-low line after a bad stop: only a return to idle re-arms start detection.
        BREAK: if (rxs) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
